// File: rtl/top_pkg.sv
// Shared constants, FSM state encoding and the requantization helper for the
// FC-layer / requantize engine.
package top_pkg;

    localparam int DATA_SIZE     = 32;

    localparam int IF_WORDS_MLP0 = 16;
    localparam int W_WORDS       = 1024;
    localparam int B_WORDS       = 16;
    localparam int IF_WORDS_MLP3 = 32;

    localparam int LEN_MLP0      = 64;
    localparam int LEN_MLP3      = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IF,
        LOAD_W,
        LOAD_B,
        COMPUTE,
        OUTPUT,
        DONE
    } state_t;

    // Round-half-up Q0.12 scaling followed by int8 saturation.
    function automatic logic [7:0] requant(input logic signed [31:0] acc,
                                           input logic [11:0] scale);
        logic signed [44:0] acc_x;
        logic signed [44:0] scale_x;
        logic signed [44:0] prod;
        logic signed [32:0] shifted;
        acc_x   = 45'(acc);
        scale_x = $signed({33'd0, scale});
        prod    = acc_x * scale_x + 45'sd2048;
        shifted = 33'(prod >>> 12);
        if (shifted > 33'sd127)
            return 8'h7f;
        else if (shifted < -33'sd128)
            return 8'h80;
        else
            return shifted[7:0];
    endfunction

endpackage

// File: rtl/mac4.sv
// Four-lane signed int8 multiply, summed into a 32-bit accumulator value.
module mac4 (
    input  logic [31:0] x,
    input  logic [31:0] w,
    input  logic [31:0] acc_in,
    output logic [31:0] acc_out
);

    logic signed [15:0] prod [4];
    logic        [31:0] sum;

    always_comb begin
        sum = acc_in;
        for (int k = 0; k < 4; k++) begin
            prod[k] = $signed(x[8*k +: 8]) * $signed(w[8*k +: 8]);
            sum     = sum + {{16{prod[k][15]}}, prod[k]};
        end
        acc_out = sum;
    end

endmodule

// File: rtl/top.sv
// Streaming 64-wide FC layer (mode 0) or 128-element requantizer (mode 1)
// with int8 inputs/outputs and a Q0.12 output scale.
//
// state   | meaning
// IDLE    | wait for ready pulse, latch mode/scale, clear accumulators
// LOAD_IF | capture ifmap words (mode 1 also seeds accumulators)
// LOAD_W  | one weight word per cycle, 4 MACs into acc[row]
// LOAD_B  | add bias to acc[0..63]
// COMPUTE | emit the first requantized output
// OUTPUT  | stream remaining outputs, one per cycle
// DONE    | one-cycle done pulse
module top #(
    parameter int DATA_SIZE = top_pkg::DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [11:0]          scaling_factor,
    input  logic                 ready,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] ofmap,
    output logic                 done
);
    import top_pkg::*;

    state_t             state;
    logic               mode_q;
    logic [11:0]        scale_q;
    logic [9:0]         word_cnt;
    logic [7:0]         out_cnt;
    logic [7:0]         ifbuf [128];
    logic signed [31:0] acc   [128];

    logic [31:0] mac_x;
    logic [31:0] mac_out;
    logic [7:0]  y;
    logic [7:0]  out_len;

    // ifmap bytes matching the current weight word (column group word_cnt[3:0])
    assign mac_x = {ifbuf[{1'b0, word_cnt[3:0], 2'd3}],
                    ifbuf[{1'b0, word_cnt[3:0], 2'd2}],
                    ifbuf[{1'b0, word_cnt[3:0], 2'd1}],
                    ifbuf[{1'b0, word_cnt[3:0], 2'd0}]};

    mac4 u_mac4 (
        .x       (mac_x),
        .w       (data_in[31:0]),
        .acc_in  (acc[{1'b0, word_cnt[9:4]}]),
        .acc_out (mac_out)
    );

    assign y       = requant(acc[out_cnt[6:0]], scale_q);
    assign out_len = mode_q ? 8'(LEN_MLP3) : 8'(LEN_MLP0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            done     <= 1'b0;
            ofmap    <= '0;
            word_cnt <= '0;
            out_cnt  <= '0;
            mode_q   <= 1'b0;
            scale_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        mode_q   <= mode;
                        scale_q  <= scaling_factor;
                        word_cnt <= '0;
                        out_cnt  <= '0;
                        for (int i = 0; i < 128; i++) acc[i] <= '0;
                        state    <= LOAD_IF;
                    end
                end
                LOAD_IF: begin
                    for (int k = 0; k < 4; k++) begin
                        ifbuf[{word_cnt[4:0], 2'(k)}] <= data_in[8*k +: 8];
                        if (mode_q)
                            acc[{word_cnt[4:0], 2'(k)}] <=
                                {{24{data_in[8*k+7]}}, data_in[8*k +: 8]};
                    end
                    if (mode_q ? (word_cnt == 10'(IF_WORDS_MLP3 - 1))
                               : (word_cnt == 10'(IF_WORDS_MLP0 - 1))) begin
                        word_cnt <= '0;
                        state    <= mode_q ? COMPUTE : LOAD_W;
                    end else begin
                        word_cnt <= word_cnt + 10'd1;
                    end
                end
                LOAD_W: begin
                    acc[{1'b0, word_cnt[9:4]}] <= mac_out;
                    if (word_cnt == 10'(W_WORDS - 1)) begin
                        word_cnt <= '0;
                        state    <= LOAD_B;
                    end else begin
                        word_cnt <= word_cnt + 10'd1;
                    end
                end
                LOAD_B: begin
                    for (int k = 0; k < 4; k++)
                        acc[{1'b0, word_cnt[3:0], 2'(k)}] <=
                            acc[{1'b0, word_cnt[3:0], 2'(k)}] +
                            {{24{data_in[8*k+7]}}, data_in[8*k +: 8]};
                    if (word_cnt == 10'(B_WORDS - 1)) begin
                        word_cnt <= '0;
                        state    <= COMPUTE;
                    end else begin
                        word_cnt <= word_cnt + 10'd1;
                    end
                end
                COMPUTE: begin
                    ofmap   <= {{(DATA_SIZE-8){y[7]}}, y};
                    valid   <= 1'b1;
                    out_cnt <= 8'd1;
                    state   <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_cnt == out_len) begin
                        valid <= 1'b0;
                        ofmap <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ofmap   <= {{(DATA_SIZE-8){y[7]}}, y};
                        out_cnt <= out_cnt + 8'd1;
                    end
                end
                DONE: begin
                    word_cnt <= '0;
                    out_cnt  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops
// and compares whenever valid is high.
module tb_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [11:0] scaling_factor;
    logic        ready;
    logic [31:0] data_in;
    logic        valid;
    logic [31:0] ofmap;
    logic        done;

    top dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .scaling_factor (scaling_factor),
        .ready          (ready),
        .data_in        (data_in),
        .valid          (valid),
        .ofmap          (ofmap),
        .done           (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    int          x [128];
    int          w [64][64];
    int          b [64];
    int          exp_len  = 0;
    int          run_len  = 0;
    int          done_cnt = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int requant_model(input int acc, input int scale);
        longint p;
        p = longint'(acc) * longint'(scale) + 64'sd2048;
        p = p >>> 12;
        if (p > 127) return 127;
        if (p < -128) return -128;
        return int'(p);
    endfunction

    function automatic logic [31:0] pack4(input int a, input int bb, input int c, input int d);
        return {d[7:0], c[7:0], bb[7:0], a[7:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if (exp_q.size() == 0)
                    check("pending_outputs", 32'(exp_q.size()), 32'd1);
                else
                    check("ofmap", ofmap, exp_q.pop_front());
                run_len++;
            end else begin
                check("ofmap_idle_zero", ofmap, 32'd0);
            end
            if (done) begin
                check("done_after_last_valid", 32'(prev_valid), 32'd1);
                check("valid_run_length", 32'(run_len), 32'(exp_len));
                check("queue_drained", 32'(exp_q.size()), 32'd0);
                run_len = 0;
                done_cnt++;
            end
            prev_valid = valid;
        end else begin
            run_len    = 0;
            prev_valid = 1'b0;
        end
    end

    task automatic start(input logic m, input logic [11:0] s);
        @(posedge clk); #1;
        mode = m; scaling_factor = s; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0; mode = 1'b0; scaling_factor = 12'd0;
    endtask

    task automatic send(input logic [31:0] wd);
        data_in = wd;
        @(posedge clk); #1;
    endtask

    task automatic push_mode0(input int s);
        for (int j = 0; j < 64; j++) begin
            int a;
            a = b[j];
            for (int i = 0; i < 64; i++) a += x[i] * w[j][i];
            exp_q.push_back(32'(requant_model(a, s)));
        end
        exp_len = 64;
    endtask

    // Streams a mode-0 job; stops after n_words if n_words < 1056.
    task automatic stream_mode0(input int n_words);
        int sent;
        sent = 0;
        for (int t = 0; t < 16 && sent < n_words; t++, sent++)
            send(pack4(x[4*t], x[4*t+1], x[4*t+2], x[4*t+3]));
        for (int t = 0; t < 1024 && sent < n_words; t++, sent++) begin
            int j, i0;
            j  = t / 16;
            i0 = (t % 16) * 4;
            send(pack4(w[j][i0], w[j][i0+1], w[j][i0+2], w[j][i0+3]));
        end
        for (int t = 0; t < 16 && sent < n_words; t++, sent++)
            send(pack4(b[4*t], b[4*t+1], b[4*t+2], b[4*t+3]));
    endtask

    task automatic wait_done(input int prev);
        int cyc;
        cyc = 0;
        while (done_cnt == prev && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 32'(done_cnt), 32'(prev + 1));
    endtask

    task automatic run_mode0(input int s);
        int prev;
        prev = done_cnt;
        push_mode0(s);
        start(1'b0, 12'(s));
        stream_mode0(1056);
        wait_done(prev);
    endtask

    task automatic run_mode1(input int s);
        int prev;
        prev = done_cnt;
        for (int i = 0; i < 128; i++) exp_q.push_back(32'(requant_model(x[i], s)));
        exp_len = 128;
        start(1'b1, 12'(s));
        for (int t = 0; t < 32; t++) send(pack4(x[4*t], x[4*t+1], x[4*t+2], x[4*t+3]));
        wait_done(prev);
    endtask

    task automatic fill0(input int xv, input int wv, input int bv);
        for (int i = 0; i < 64; i++) begin
            x[i] = xv;
            b[i] = bv;
            for (int k = 0; k < 64; k++) w[i][k] = wv;
        end
    endtask

    initial begin
        int prev;
        rst = 1'b1; mode = 1'b0; scaling_factor = 12'd0; ready = 1'b0; data_in = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ofmap", ofmap, 32'd0);
        #1 rst = 1'b0;

        fill0(1, 1, 0);
        run_mode0(64);

        fill0(127, 127, 0);
        run_mode0(4095);

        fill0(-128, 127, 0);
        run_mode0(4095);

        fill0(0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            x[i] = i - 32;
            w[i][i] = 1;
        end
        run_mode0(4095);

        for (int i = 0; i < 128; i++) x[i] = i;
        run_mode1(2048);

        // abort mid weight load with a dirty data set
        fill0(100, -77, 55);
        start(1'b0, 12'd4000);
        stream_mode0(16 + 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);

        // fresh run, with a stray ready pulse during OUTPUT
        for (int i = 0; i < 64; i++) begin
            x[i] = (i % 7) - 3;
            b[i] = i - 32;
            for (int k = 0; k < 64; k++) w[i][k] = ((k + 2 * i) % 5) - 2;
        end
        prev = done_cnt;
        push_mode0(1000);
        start(1'b0, 12'd1000);
        stream_mode0(1056);
        repeat (10) @(posedge clk);
        #1;
        check("valid_in_output", 32'(valid), 32'd1);
        mode = 1'b1; scaling_factor = 12'd2048; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0; mode = 1'b0; scaling_factor = 12'd0;
        wait_done(prev);
        repeat (20) @(posedge clk);
        #1;
        check("no_restart_after_stray_ready", 32'(done_cnt), 32'(prev + 1));

        for (int i = 0; i < 128; i++) x[i] = ((i * 37) % 256) - 128;
        run_mode1(4095);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
